// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT coefficient buffer: controller state
// encoding and the address-width rule used on the NTT-side ports.
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ntt_state_t;

    // NTT-side address ports are at least 10 bits wide so the wrapper can be
    // shared with larger polynomial sizes; only the low row bits are used here.
    function automatic int ntt_addr_width(input int logn);
        return ((logn < 9) ? 9 : logn) + 1;
    endfunction

endpackage

// File: rtl/ntt_coeff_bank.sv
// Simple dual-port coefficient bank: one write port, one read port with a
// DELAY-deep registered read path that freezes when i_re is low.
module ntt_coeff_bank #(
    parameter int WIDTH = 64,
    parameter int ABITS = 3,
    parameter int DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [ABITS-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [ABITS-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ABITS;

    logic [WIDTH-1:0] r_mem  [DEPTH];
    logic [WIDTH-1:0] r_pipe [DELAY];

    // Storage array: never reset, so contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read pipeline: stage 0 samples the array, later stages shift; the whole
    // path holds when i_re is low so a stalled consumer sees stable data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DELAY; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (i_re) begin
            r_pipe[0] <= r_mem[i_raddr];
            for (int i = 1; i < DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_rdata = r_pipe[DELAY-1];

endmodule

// File: rtl/ntt_coeff_buffer.sv
// Coefficient buffer around an NTT memory wrapper: loads N coefficients from a
// stream, exposes them as two half-banks to the NTT engine, then streams the
// transformed result back out in natural order.
module ntt_coeff_buffer
    import ntt_pkg::*;
#(
    parameter int LOGQ       = 64,
    parameter int LOGN       = 4,
    parameter int DELAY_BRAM = 1,
    localparam int AW        = ntt_addr_width(LOGN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [LOGQ-1:0] s_data,
    output logic            ntt_start,
    input  logic            ntt_finish,
    input  logic [AW-1:0]   ntt_read_address,
    output logic [LOGQ-1:0] ntt_data_in_0,
    output logic [LOGQ-1:0] ntt_data_in_1,
    input  logic [AW-1:0]   ntt_write_address,
    input  logic            ntt_wea,
    input  logic [LOGQ-1:0] ntt_data_out_0,
    input  logic [LOGQ-1:0] ntt_data_out_1,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [LOGQ-1:0] m_data,
    output logic            busy
);

    localparam int RB = LOGN - 1;
    localparam logic [LOGN-1:0] LAST_IDX = LOGN'((2 ** LOGN) - 1);

    ntt_state_t r_state;
    ntt_state_t w_nextState;

    logic [LOGN-1:0]       r_loadIdx;
    logic [LOGN:0]         r_issueIdx;
    logic [LOGN-1:0]       r_outIdx;
    logic [DELAY_BRAM-1:0] r_validPipe;
    logic [DELAY_BRAM-1:0] r_selPipe;

    logic            w_loadFire;
    logic            w_advance;
    logic            w_issue;
    logic            w_outFire;
    logic            w_drainDone;
    logic            w_we0;
    logic            w_we1;
    logic [RB-1:0]   w_waddr;
    logic [LOGQ-1:0] w_wdata0;
    logic [LOGQ-1:0] w_wdata1;
    logic            w_re;
    logic [RB-1:0]   w_raddr;
    logic [LOGQ-1:0] w_rdata0;
    logic [LOGQ-1:0] w_rdata1;
    logic            w_unusedAddrBits;

    assign w_unusedAddrBits = ^{ntt_read_address[AW-1:RB], ntt_write_address[AW-1:RB]};

    assign w_loadFire  = (r_state == ST_LOAD) && s_valid;
    assign w_advance   = !m_valid || m_ready;
    assign w_issue     = (r_state == ST_DRAIN) && w_advance && !r_issueIdx[LOGN];
    assign w_outFire   = m_valid && m_ready;
    assign w_drainDone = w_outFire && (r_outIdx == LAST_IDX);

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic and the state-decoded handshake/status outputs.
    always_comb begin
        w_nextState = r_state;
        s_ready     = 1'b0;
        ntt_start   = 1'b0;
        busy        = 1'b1;
        unique case (r_state)
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = (r_loadIdx != '0);
                if (w_loadFire && (r_loadIdx == LAST_IDX)) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                ntt_start = 1'b1;
                if (ntt_finish) begin
                    w_nextState = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drainDone) begin
                    w_nextState = ST_LOAD;
                end
            end
            default: begin
                w_nextState = ST_LOAD;
            end
        endcase
    end

    // Load index: bit LOGN-1 picks the bank, wraps to 0 after the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loadIdx <= '0;
        end else if (w_loadFire) begin
            r_loadIdx <= r_loadIdx + 1'b1;
        end
    end

    // Drain counters: issue index runs one extra bit to mark "all issued",
    // output index counts accepted words; both return to 0 outside DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issueIdx <= '0;
            r_outIdx   <= '0;
        end else if ((r_state != ST_DRAIN) || w_drainDone) begin
            r_issueIdx <= '0;
            r_outIdx   <= '0;
        end else begin
            if (w_issue) begin
                r_issueIdx <= r_issueIdx + 1'b1;
            end
            if (w_outFire) begin
                r_outIdx <= r_outIdx + 1'b1;
            end
        end
    end

    // Valid and bank-select tags travel alongside the bank read pipeline and
    // stall with it, so m_data and m_valid stay aligned under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_validPipe <= '0;
            r_selPipe   <= '0;
        end else if ((r_state != ST_DRAIN) || w_drainDone) begin
            r_validPipe <= '0;
        end else if (w_advance) begin
            r_validPipe[0] <= w_issue;
            r_selPipe[0]   <= r_issueIdx[LOGN-1];
            for (int i = 1; i < DELAY_BRAM; i++) begin
                r_validPipe[i] <= r_validPipe[i-1];
                r_selPipe[i]   <= r_selPipe[i-1];
            end
        end
    end

    // Single write port per bank: the stream owns it in LOAD, the NTT wrapper
    // in RUN, and nobody writes in DRAIN.
    always_comb begin
        w_we0    = 1'b0;
        w_we1    = 1'b0;
        w_waddr  = '0;
        w_wdata0 = '0;
        w_wdata1 = '0;
        unique case (r_state)
            ST_LOAD: begin
                w_waddr  = r_loadIdx[RB-1:0];
                w_wdata0 = s_data;
                w_wdata1 = s_data;
                w_we0    = s_valid && !r_loadIdx[LOGN-1];
                w_we1    = s_valid && r_loadIdx[LOGN-1];
            end
            ST_RUN: begin
                w_waddr  = ntt_write_address[RB-1:0];
                w_wdata0 = ntt_data_out_0;
                w_wdata1 = ntt_data_out_1;
                w_we0    = ntt_wea;
                w_we1    = ntt_wea;
            end
            default: begin
            end
        endcase
    end

    // Read port: the NTT address streams freely in RUN; in DRAIN the drain
    // counter drives it and the pipeline only moves when the output can.
    always_comb begin
        w_re    = 1'b0;
        w_raddr = r_issueIdx[RB-1:0];
        if (r_state == ST_RUN) begin
            w_re    = 1'b1;
            w_raddr = ntt_read_address[RB-1:0];
        end else if (r_state == ST_DRAIN) begin
            w_re    = w_advance;
        end
    end

    ntt_coeff_bank #(
        .WIDTH (LOGQ),
        .ABITS (RB),
        .DELAY (DELAY_BRAM)
    ) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we0),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata0),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata0)
    );

    ntt_coeff_bank #(
        .WIDTH (LOGQ),
        .ABITS (RB),
        .DELAY (DELAY_BRAM)
    ) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we1),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata1),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata1)
    );

    assign ntt_data_in_0 = w_rdata0;
    assign ntt_data_in_1 = w_rdata1;
    assign m_valid       = r_validPipe[DELAY_BRAM-1];
    assign m_data        = r_selPipe[DELAY_BRAM-1] ? w_rdata1 : w_rdata0;

endmodule

// File: doc/ntt_coeff_buffer.md
NTT_COEFF_BUFFER -- requirements
Module: ntt_coeff_buffer

Interface
REQ-001 The module SHALL have parameter LOGQ, default 64, giving the coefficient bit width.
REQ-002 The module SHALL have parameter LOGN, default 4, with N = 2**LOGN coefficients per polynomial.
REQ-003 The module SHALL have parameter DELAY_BRAM, default 1, giving the bank read latency in cycles; only 1 and 2 are legal.
REQ-004 The module SHALL use AW = ((LOGN<9) ? 9 : LOGN)+1 for all NTT-side address ports.
REQ-005 clk, input, 1: single clock; all logic is rising-edge.
REQ-006 rst, input, 1: reset, asynchronous, active-high.
REQ-007 s_valid, input, 1: load-stream word valid.
REQ-008 s_ready, output, 1: load-stream ready.
REQ-009 s_data, input, LOGQ: load coefficient, in natural order, index 0..N-1.
REQ-010 ntt_start, output, 1: start level driven to the NTT memory wrapper.
REQ-011 ntt_finish, input, 1: finish pulse from the wrapper.
REQ-012 ntt_read_address, input, AW: wrapper read index.
REQ-013 ntt_data_in_0 and ntt_data_in_1, outputs, LOGQ each: coefficient[addr] and coefficient[addr+N/2].
REQ-014 ntt_write_address, input, AW: wrapper write-back index.
REQ-015 ntt_wea, input, 1: write-back enable.
REQ-016 ntt_data_out_0 and ntt_data_out_1, inputs, LOGQ each: write-back values for addr and addr+N/2.
REQ-017 m_valid, output, 1: result-stream word valid.
REQ-018 m_ready, input, 1: result-stream ready.
REQ-019 m_data, output, LOGQ: result coefficient, in natural order.
REQ-020 busy, output, 1: high in every state except LOAD with zero words accepted.

Function
REQ-021 Storage SHALL be two banks of N/2 x LOGQ each: bank0 holds indices 0..N/2-1 and bank1 holds indices N/2..N-1. Index bit LOGN-1 selects the bank; bits [LOGN-2:0] give the row.
REQ-022 The FSM SHALL have exactly three states: LOAD, RUN and DRAIN.
REQ-023 In LOAD:
- s_ready SHALL be 1.
- Each s_valid&s_ready handshake SHALL write s_data at load index k, then increment k.
- The handshake with k=N-1 SHALL move the FSM to RUN on the next cycle and clear k.
REQ-024 In RUN:
- ntt_start SHALL be 1 and s_ready SHALL be 0.
- ntt_data_in_0 and ntt_data_in_1 SHALL present bank0 and bank1 at row ntt_read_address[LOGN-2:0], exactly DELAY_BRAM cycles after that address. Upper address bits are ignored.
REQ-025 In RUN, ntt_wea=1 SHALL write ntt_data_out_0 to bank0 and ntt_data_out_1 to bank1 at row ntt_write_address[LOGN-2:0]. This includes a write in the same cycle as ntt_finish.
REQ-026 ntt_finish=1 in RUN SHALL move the FSM to DRAIN on the next cycle, and ntt_start SHALL be 0 from that cycle. ntt_finish outside RUN SHALL be ignored.
REQ-027 In DRAIN:
- The buffer SHALL emit indices 0..N-1 in order on m_data using valid/ready.
- m_valid SHALL rise DELAY_BRAM cycles after DRAIN entry.
- While m_valid&!m_ready, m_data SHALL hold stable.
- The buffer SHALL sustain one word per cycle while m_ready=1.
REQ-028 The handshake of index N-1 SHALL return the FSM to LOAD, with m_valid 0 the next cycle. Drain counters SHALL wrap to 0.
REQ-029 ntt_wea and read activity outside RUN SHALL NOT modify the banks.
REQ-030 Simultaneous load-port and NTT-port writes cannot occur because the ports are state-exclusive. Each bank SHALL have one write port, muxed by state.

Reset
REQ-031 rst=1 SHALL immediately force:
- the FSM to LOAD and all counters to 0;
- s_ready=1 and ntt_start=0;
- ntt_data_in_0, ntt_data_in_1, m_data = 0;
- m_valid=0 and busy=0.
REQ-032 Reset SHALL NOT clear bank contents. Reset in any state, mid-operation, SHALL abandon that operation.

Structure
REQ-033 Package ntt_pkg SHALL hold the AW width function and the LOAD/RUN/DRAIN state encoding.
REQ-034 Sub-module ntt_coeff_bank SHALL be used: a simple dual-port RAM of N/2 x LOGQ, with one write and one read port and DELAY_BRAM read latency, instantiated twice.
REQ-035 Each bank's read-address mux SHALL select ntt_read_address in RUN and the drain counter in DRAIN.

Verification (LOGN=4, N=16, DELAY_BRAM=1)
REQ-036 Load s_data=i+1 for i=0..15 with s_valid constant -> ntt_start=1 on the cycle after the 16th handshake; s_ready=0 from then on.
REQ-037 In RUN, drive ntt_read_address=3 at cycle t -> at t+1, ntt_data_in_0=4 and ntt_data_in_1=12.
REQ-038 Drive ntt_wea=1, write_address=5, out_0=0xAA, out_1=0xBB in the same cycle as ntt_finish, then drain -> index 5 = 0xAA, index 13 = 0xBB, all other indices unchanged.
REQ-039 In DRAIN, toggle m_ready 1,0,1,0 -> m_data stable during stalls; exactly 16 handshakes occur, then s_ready=1.
REQ-040 Assert rst after 7 load handshakes -> outputs take reset values immediately; a following load of 16 words starts at index 0, and read index 0 returns the first new word.
REQ-041 Hold s_valid=1 through RUN and DRAIN, and pulse ntt_finish while in LOAD -> no words are accepted and the state does not change.
